// File: rtl/bcd2b.sv
// Iterative BCD-to-binary converter: one digit per clock, MSD first, acc = acc*10 + digit.
// Define BCD2B_CHECK_EN to compile in digit validity checking (err output); otherwise err is 0.
module bcd2b #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BW     = 14
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [4*DIGITS-1:0]   i_bcd_in,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [BW-1:0]         o_bin_out,
  output logic                  o_err
);

  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(DIGITS - 1);

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e              r_state;
  logic [4*DIGITS-1:0] r_shreg;
  logic [BW-1:0]       r_acc;
  logic [CW-1:0]       r_cnt;
  logic                r_done;
  logic [BW-1:0]       r_bin;
  logic                r_err;

  logic [3:0]          w_digit;
  logic [BW-1:0]       w_acc_next;
  logic                w_err_next;

  assign w_digit    = r_shreg[4*DIGITS-1 -: 4];
  // acc*10 as acc*8 + acc*2, truncated to BW bits
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + BW'(w_digit);

`ifdef BCD2B_CHECK_EN
  logic r_err_flag;
  assign w_err_next = r_err_flag | (w_digit > 4'd9);
`else
  assign w_err_next = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_shreg <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_bin   <= '0;
      r_err   <= 1'b0;
`ifdef BCD2B_CHECK_EN
      r_err_flag <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_shreg <= i_bcd_in;
            r_acc   <= '0;
            r_cnt   <= '0;
`ifdef BCD2B_CHECK_EN
            r_err_flag <= 1'b0;
`endif
            r_state <= StConv;
          end
        end
        StConv: begin
          r_acc   <= w_acc_next;
          r_shreg <= r_shreg << 4;
          r_cnt   <= r_cnt + 1'b1;
`ifdef BCD2B_CHECK_EN
          r_err_flag <= w_err_next;
`endif
          if (r_cnt == LastIdx) begin
            r_bin   <= w_err_next ? '0 : w_acc_next;
            r_err   <= w_err_next;
            r_done  <= 1'b1;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy    = (r_state == StConv);
  assign o_done    = r_done;
  assign o_bin_out = r_bin;
  assign o_err     = r_err;

endmodule

// File: tb/tb_bcd2b.sv
// Directed self-checking bench for bcd2b (DIGITS=4, BW=14); expectations follow BCD2B_CHECK_EN.
module tb_bcd2b;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic [13:0] bin_out;
  logic        err;

  int n_chk;
  int n_err;

  bcd2b #(.DIGITS(4), .BW(14)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_bcd_in  (bcd_in),
    .o_busy    (busy),
    .o_done    (done),
    .o_bin_out (bin_out),
    .o_err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts a conversion and checks the full DIGITS-cycle timeline; ends in the done cycle.
  task automatic conv(input logic [15:0] bcd, input int exp_bin, input logic exp_err,
                      input string tag);
    bcd_in = bcd;
    start  = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " busy@accept"}, busy, 1);
    chk({tag, " done@accept"}, done, 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk({tag, " busy@digit"}, busy, 1);
      chk({tag, " done@digit"}, done, 0);
    end
    tick();
    chk({tag, " done"}, done, 1);
    chk({tag, " busy@done"}, busy, 0);
    chk({tag, " bin_out"}, bin_out, exp_bin);
    chk({tag, " err"}, err, exp_err);
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = 16'h0000;
    tick();
    tick();
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset bin_out", bin_out, 0);
    chk("reset err", err, 0);
    rst = 1'b0;
    tick();

    conv(16'h1234, 1234, 1'b0, "basic");
    tick();
    chk("basic done falls", done, 0);
    chk("basic bin holds", bin_out, 1234);

    conv(16'h9999, 9999, 1'b0, "max");
    tick();
    conv(16'h0000, 0, 1'b0, "zero");
    tick();
    chk("zero done falls", done, 0);

`ifdef BCD2B_CHECK_EN
    conv(16'h12A4, 0, 1'b1, "invalid");
`else
    conv(16'h12A4, 1304, 1'b0, "invalid");
`endif
    tick();

    // Second start while busy is ignored; bcd_in changing mid-flight is not sampled.
    bcd_in = 16'h0567;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bcd_in = 16'h9999;
    start  = 1'b1;
    tick();
    start = 1'b0;
    chk("ignore busy", busy, 1);
    tick();
    tick();
    chk("ignore done", done, 1);
    chk("ignore bin_out", bin_out, 567);
    tick();
    chk("ignore no queue busy", busy, 0);
    chk("ignore single done", done, 0);
    tick();
    chk("ignore idle busy", busy, 0);

    // Back-to-back: second start issued in the done cycle.
    conv(16'h0123, 123, 1'b0, "b2b first");
    conv(16'h0042, 42, 1'b0, "b2b second");
    tick();

    // Reset mid-conversion aborts with no done pulse.
    bcd_in = 16'h1234;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort bin_out", bin_out, 0);
    chk("abort err", err, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort no done", done, 0);
    end
    conv(16'h0007, 7, 1'b0, "after abort");
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd2b.md
# bcd2b

Iterative BCD-to-binary converter: the decode-side counterpart to the codebase's binary-to-BCD encoders. It accepts a packed multi-digit BCD word with a start strobe and processes one decimal digit per clock, most-significant digit first, using acc = acc*10 + digit. It signals completion with a one-cycle done pulse and holds the binary result until the next conversion. It sits between decimal-entry/display-side logic and binary datapaths.

## Interface
- DIGITS, 4: number of packed BCD digits; legal range 1..8.
- BW, 14: binary result width. Must satisfy 2^BW > 10^DIGITS - 1 (14 for 4 digits).
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  conversion request; sampled only while idle.
- bcd_in  in  4*DIGITS  packed BCD; digit DIGITS-1 in the top nibble. Sampled on the accepting edge only.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse: bin_out and err are valid and updated.
- bin_out  out  BW  binary result; holds between done pulses.
- err  out  1  a digit > 9 was seen. Only present in behaviour when BCD2B_CHECK_EN is defined; otherwise tied 0.

## Operation
- State IDLE:
  - busy=0.
  - On a clock edge with start=1: latch bcd_in into a shift register, clear the accumulator, clear the digit counter and the error flag, and go to CONV.
- State CONV:
  - busy=1.
  - Each edge: acc <= acc*10 + shreg[top nibble]; shreg <<= 4; counter increments.
  - The *10 uses shifts and adds (acc<<3 + acc<<1). All arithmetic is truncated to BW bits (modulo 2^BW).
  - With BCD2B_CHECK_EN defined, a top nibble > 9 sets the sticky error flag.
  - On the edge that processes digit index DIGITS-1: bin_out <= final acc (or 0 if the error flag is set), err <= error flag, done <= 1, return to IDLE.
- done deasserts on the following edge unless a new conversion completes.
- start while busy=1 is ignored; it is not queued.
- start in the cycle where done=1 is accepted, because the block is already IDLE. This gives back-to-back conversions every DIGITS+1 cycles.
- bcd_in changes after the accepting edge do not affect the conversion in flight.
- Reset, from any state: IDLE, busy=0, done=0, bin_out=0, err=0, accumulator, shift register and counter cleared.
- Reset mid-conversion aborts it. No done pulse is produced and bin_out keeps its reset value of 0.

## Timing
- start accepted at edge n → busy=1 after edge n.
- Digits are processed on edges n+1 … n+DIGITS.
- After edge n+DIGITS: done=1, busy=0, and bin_out/err are valid. Latency is DIGITS edges after the accept edge (4 for defaults).
- done is high for exactly one cycle per completed conversion.
- Throughput: one conversion per DIGITS+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- BCD2B_CHECK_EN defined:
  - Digit validity checking is compiled in.
  - Any nibble > 9 makes that conversion report err=1 and bin_out=0. Latency and the done pulse are unchanged.
- BCD2B_CHECK_EN undefined:
  - The checker is compiled out and err is constant 0.
  - Invalid nibbles are weighted by their raw value (0xA=10 … 0xF=15), and the result is truncated to BW bits.

## Test plan
- Basic conversion: after reset, start with bcd_in=0x1234 → done high exactly 4 cycles after the accept edge, bin_out=1234 (0x04D2), err=0, busy high for those 4 cycles.
- Extremes: bcd_in=0x9999 → bin_out=9999 (0x270F); then bcd_in=0x0000 → bin_out=0, with done pulsing once per conversion.
- Invalid digit: bcd_in=0x12A4 → with BCD2B_CHECK_EN: err=1, bin_out=0. Without it: err=0, bin_out=1304.
- Handshake:
  - Pulse start again 2 cycles into a conversion of 0x0567 → ignored; a single done with bin_out=567.
  - Start 0x0042 in the done cycle → second done exactly 5 cycles after the first, bin_out=42.
  - Changing bcd_in mid-conversion → result unaffected.
- Reset mid-conversion: assert rst 2 cycles after starting 0x1234 → next cycle busy=0, done=0, bin_out=0; no done ever appears for the aborted conversion. A subsequent start of 0x0007 → bin_out=7.
